// File: rtl/op_phase_sequencer.sv
// Multi-cycle phase controller for the single-issue LEGv8 datapath: one FSM issuing
// one-hot phase enables, owning the PC, and stalling on data memory with a timeout.
module op_phase_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               halt_req,
    input  logic               mem_access,
    input  logic               mem_ready,
    input  logic               reg_write_ctl,
    input  logic               branch_taken,
    input  logic [31:0]        pc_offset,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               execute_en,
    output logic               mem_en,
    output logic               wb_en,
    output logic               reg_write_en,
    output logic [31:0]        pc,
    output logic               busy,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StFault
    } state_e;

    // wait_cnt holds completed stall cycles; the last allowed stall faults.
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [4:0]         en_q, en_d;
    logic [31:0]        pc_q, pc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               timeout_q, timeout_d;
    logic               halt_pending_q, halt_pending_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic               taken_q, taken_d;
    logic [31:0]        offset_bytes;

    assign offset_bytes = pc_offset << 2;
    assign busy = (state_q != StIdle) && (state_q != StFault);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        count_d        = count_q;
        timeout_d      = timeout_q;
        wait_cnt_d     = wait_cnt_q;
        taken_d        = taken_q;
        halt_pending_d = halt_pending_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch:   state_d = StDecode;
            StDecode:  state_d = StExecute;
            StExecute: begin
                taken_d = branch_taken;
                state_d = StMemory;
            end
            StMemory: begin
                // A completion arriving on the final allowed stall still wins over the fault.
                if (!mem_access || mem_ready) begin
                    state_d    = StWriteback;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d    = StFault;
                    timeout_d  = 1'b1;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StWriteback: begin
                pc_d    = taken_q ? pc_q + offset_bytes : pc_q + 32'd4;
                count_d = count_q + COUNT_W'(1);
                state_d = (halt_pending_q || halt_req) ? StIdle : StFetch;
            end
            StFault:   state_d = StFault;
            default:   state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            halt_pending_d = 1'b0;
        end else if (halt_req && busy) begin
            halt_pending_d = 1'b1;
        end

        en_d = {state_d == StFetch, state_d == StDecode, state_d == StExecute,
                state_d == StMemory, state_d == StWriteback};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            en_q           <= 5'b0;
            pc_q           <= RESET_PC;
            count_q        <= '0;
            timeout_q      <= 1'b0;
            halt_pending_q <= 1'b0;
            wait_cnt_q     <= 8'd0;
            taken_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            en_q           <= en_d;
            pc_q           <= pc_d;
            count_q        <= count_d;
            timeout_q      <= timeout_d;
            halt_pending_q <= halt_pending_d;
            wait_cnt_q     <= wait_cnt_d;
            taken_q        <= taken_d;
        end
    end

    assign fetch_en     = en_q[4];
    assign decode_en    = en_q[3];
    assign execute_en   = en_q[2];
    assign mem_en       = en_q[1];
    assign wb_en        = en_q[0];
    assign reg_write_en = wb_en & reg_write_ctl;
    assign pc           = pc_q;
    assign timeout_err  = timeout_q;
    assign instr_count  = count_q;

endmodule

// File: doc/op_phase_sequencer.md
Name: op_phase_sequencer

Overview:
Multi-cycle phase controller for the single-issue LEGv8 datapath. It replaces the free-running per-stage phase counters with one FSM. The FSM issues one-hot phase enables for fetch, operand prep (register read), execute, memory and writeback. It gates register-file writes to the writeback phase, owns the PC register and stalls on data-memory handshakes with a timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 15, max cycles waiting in MEMORY for mem_ready before fault (1..255)
COUNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  main clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  leave IDLE and begin fetching (level, sampled in IDLE only)
halt_req  in  1  request stop after current instruction retires (pulse or level)
mem_access  in  1  decoded: current instruction is load/store (memReadFlag|memWriteFlag)
mem_ready  in  1  data memory completion strobe
reg_write_ctl  in  1  decoded regWrite for current instruction
branch_taken  in  1  branch resolved taken (valid in EXECUTE)
pc_offset  in  32  sign-extended word offset (from operand prep pcOffsetFilled)
fetch_en  out  1  FETCH phase enable
decode_en  out  1  operand-prep/register-read enable
execute_en  out  1  ALU phase enable
mem_en  out  1  memory phase enable; held through stall
wb_en  out  1  writeback phase enable
reg_write_en  out  1  wb_en & reg_write_ctl
pc  out  32  current instruction address
busy  out  1  high in any state except IDLE and FAULT
timeout_err  out  1  sticky memory-timeout fault flag
instr_count  out  COUNT_W  retired instructions

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, FAULT. Registered one-hot enables: each enable is high exactly while in its state. reg_write_en is combinational from wb_en.
- Reset (async, any time, including mid-MEMORY stall): state=IDLE, all enables 0, pc=RESET_PC, instr_count=0, timeout_err=0, halt_pending=0, wait_cnt=0, taken_q=0.
- IDLE: start=1 -> FETCH next edge; else stay. halt_req is ignored in IDLE.
- FETCH -> DECODE -> EXECUTE, one cycle each, unconditional.
- EXECUTE: latch taken_q<=branch_taken; -> MEMORY.
- MEMORY: if mem_access=0, -> WRITEBACK after 1 cycle, ignoring mem_ready. If mem_access=1, stay until mem_ready=1, then -> WRITEBACK. wait_cnt increments each stalled cycle. If wait_cnt reaches MEM_TIMEOUT with no mem_ready, -> FAULT and set timeout_err=1. mem_ready on the same edge as the count reaching MEM_TIMEOUT wins (-> WRITEBACK). wait_cnt clears on MEMORY exit.
- WRITEBACK: pc <= taken_q ? pc + (pc_offset<<2) : pc + 4. Arithmetic is 32-bit, wrap modulo 2^32, and the shift discards the upper 2 bits. instr_count increments, wrapping all-ones -> 0. Next state: IDLE if halt_pending or halt_req, else FETCH.
- halt_pending: set on any cycle halt_req=1 while busy; cleared on entry to IDLE. A halt never aborts an instruction mid-phase.
- FAULT: all enables 0, busy=0, timeout_err=1. Stays until reset; start is ignored.
- Steady throughput with no memory access: 5 cycles per instruction.
- pc and instr_count change only on the WRITEBACK edge.

Test Plan:
- Reset, start=1 for 1 cycle, mem_access=0, branch_taken=0 -> enables cycle F,D,E,M,W every 5 cycles; after 3 instructions pc=0x0C, instr_count=3; reg_write_en pulses only in W when reg_write_ctl=1.
- Branch: pc=0x10, branch_taken=1 in EXECUTE, pc_offset=32'hFFFF_FFFE -> pc=0x08 after WRITEBACK; pc_offset=3 from 0x10 -> 0x1C.
- Memory stall: mem_access=1, mem_ready asserted 4 cycles after MEMORY entry -> mem_en high 5 cycles, then WRITEBACK; timeout_err stays 0.
- Timeout: mem_access=1, mem_ready held 0 -> FAULT after 15 stalled cycles, timeout_err=1, busy=0. Start ignored; reset clears the fault.
- Halt: halt_req pulse during DECODE -> instruction completes WRITEBACK, then IDLE, busy=0. A new start resumes from the updated pc.
- Async reset asserted mid-stall (between edges) -> outputs return to reset values immediately; pc=RESET_PC, instr_count=0.
